// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit_if                                                 |
// | Core request/response and data-memory signals of the LSU.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface load_store_unit_if #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [MEM_ADDR_WIDTH+1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic                      rsp_err;
  logic [31:0]               rsp_rdata;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;

  // Master is the environment: core pipeline plus the data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit                                                    |
// | RV32I B/H/W loads and stores onto a word-only memory (RMW stores). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module load_store_unit #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]                r_state;
  logic [2:0]                w_next;
  logic                      r_we;
  logic [2:0]                r_funct3;
  logic [MEM_ADDR_WIDTH+1:0] r_addr;
  logic [31:0]               r_wdata;
  logic [MEM_DATA_WIDTH-1:0] r_mem_wdata;
  logic                      r_rsp_err;
  logic [31:0]               r_rsp_rdata;

  logic                      w_accept;
  logic                      w_illegal;
  logic                      w_misaligned;
  logic                      w_err;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [31:0]               w_load;
  logic [MEM_DATA_WIDTH-1:0] w_merged;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_err    = w_illegal || w_misaligned;

  always_comb begin
    w_illegal = 1'b0;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
      default:                w_illegal = bus.req_we && bus.req_funct3[2];
    endcase
  end

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   w_misaligned = bus.req_addr[0];
      2'b10:   w_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)
            w_next = S_RESP;
          else if (bus.req_we && (bus.req_funct3 == 3'b010))
            w_next = S_WR;
          else
            w_next = S_RD;
        end
      end
      S_RD:    w_next = S_DATA;
      S_DATA:  w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state so a reset drops them immediately
  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.rsp_valid = (r_state == S_RESP);
    bus.mem_we    = (r_state == S_WR);
  end

  assign bus.mem_addr  = r_addr[MEM_ADDR_WIDTH+1:2];
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  always_comb begin
    w_load = bus.mem_rdata[31:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.mem_rdata[31:0];
    endcase
  end

  // Store merge: only SB and SH reach DATA on the store path
  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_mem_wdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we        <= bus.req_we;
        r_funct3    <= bus.req_funct3;
        r_addr      <= bus.req_addr;
        r_wdata     <= bus.req_wdata;
        r_mem_wdata <= bus.req_wdata;
        if (w_err) begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= 32'd0;
        end
      end
      if (r_state == S_DATA) begin
        if (r_we) begin
          r_mem_wdata <= w_merged;
        end else begin
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_load;
        end
      end
      if (r_state == S_WR) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_store_unit                                                 |
// | Table vectors, hand sequences and a random run against a model.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    logic        wr;
    logic [31:0] ewd;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  vec_t        tbl [14];

  load_store_unit_if #(.MEM_ADDR_WIDTH(10), .MEM_DATA_WIDTH(32)) bus ();

  load_store_unit #(.MEM_ADDR_WIDTH(10), .MEM_DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-only synchronous memory, read-first
  always @(posedge clk) begin
    if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= env_mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Architectural reference: byte-lane arithmetic on a word array
  task automatic model(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wd, output logic err, output int lat,
                       output logic [31:0] rdata, output logic wr, output logic [31:0] nwd);
    int          off, size;
    logic        illegal;
    logic [31:0] word, mask, v;
    off  = int'(addr) % 4;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
    err   = illegal || ((int'(addr) % size) != 0);
    rdata = 32'd0;
    wr    = 1'b0;
    nwd   = 32'd0;
    word  = ref_mem[addr / 4];
    mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      v = (word >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      rdata = v;
    end else begin
      lat = (size == 4) ? 2 : 4;
      wr  = 1'b1;
      nwd = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[addr / 4] = nwd;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rdata, output int wcnt, output int wcyc,
                         output logic [31:0] wdat, output logic [9:0] wadr);
    int guard;
    lat = 0; err = 1'b0; rdata = 32'd0; wcnt = 0; wcyc = 0; wdat = 32'd0; wadr = 10'd0;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = 12'($urandom);
        bus.req_wdata  = $urandom;
      end
      if (bus.mem_we) begin
        wcnt++;
        wcyc = c;
        wdat = bus.mem_wdata;
        wadr = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        lat   = c;
        err   = bus.rsp_err;
        rdata = bus.rsp_rdata;
        break;
      end
    end
  endtask

  task automatic apply(input string tag, input logic we, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [31:0] wd, input logic e_err,
                       input int e_lat, input logic [31:0] e_rdata, input logic e_wr,
                       input logic [31:0] e_wd);
    int          lat, wcnt, wcyc;
    logic        err;
    logic [31:0] rdata, wdat;
    logic [9:0]  wadr;
    run_req(we, f3, addr, wd, lat, err, rdata, wcnt, wcyc, wdat, wadr);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " rsp_err"}, 32'(err), 32'(e_err));
    chk({tag, " rsp_rdata"}, rdata, e_rdata);
    chk({tag, " mem_we count"}, 32'(wcnt), e_wr ? 32'd1 : 32'd0);
    if (e_wr) begin
      chk({tag, " write data"}, wdat, e_wd);
      chk({tag, " write addr"}, 32'(wadr), 32'(addr[11:2]));
      chk({tag, " write cycle"}, 32'(wcyc), 32'(e_lat - 1));
    end
  endtask

  initial begin
    logic        m_err, m_wr;
    int          m_lat, cnt, pulses;
    logic [31:0] m_rd, m_wd, wd;
    logic [11:0] a;
    logic [2:0]  f3;
    logic        we;

    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 12'd0;
    bus.req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    //         we    f3    addr     wdata         err   lat rdata         wr    write word
    tbl[0]  = '{1'b1, 3'd2, 12'h010, 32'h88776655, 1'b0, 2, 32'h00000000, 1'b1, 32'h88776655};
    tbl[1]  = '{1'b0, 3'd0, 12'h013, 32'h0,        1'b0, 3, 32'hFFFFFF88, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 3'd4, 12'h013, 32'h0,        1'b0, 3, 32'h00000088, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 3'd1, 12'h012, 32'h0,        1'b0, 3, 32'hFFFF8877, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 3'd5, 12'h010, 32'h0,        1'b0, 3, 32'h00006655, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 3'd2, 12'h010, 32'h0,        1'b0, 3, 32'h88776655, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 3'd0, 12'h011, 32'hAABBCCDD, 1'b0, 4, 32'h00000000, 1'b1, 32'h8877DD55};
    tbl[7]  = '{1'b1, 3'd1, 12'h012, 32'h00001234, 1'b0, 4, 32'h00000000, 1'b1, 32'h1234DD55};
    tbl[8]  = '{1'b0, 3'd2, 12'h010, 32'h0,        1'b0, 3, 32'h1234DD55, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 3'd2, 12'h012, 32'h0,        1'b1, 1, 32'h00000000, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 3'd1, 12'h011, 32'hFFFFFFFF, 1'b1, 1, 32'h00000000, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 3'd5, 12'h013, 32'h0,        1'b1, 1, 32'h00000000, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 3'd3, 12'h010, 32'h0,        1'b1, 1, 32'h00000000, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 3'd4, 12'h010, 32'h12345678, 1'b1, 1, 32'h00000000, 1'b0, 32'h0};

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_err, m_lat, m_rd, m_wr, m_wd);
      apply($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
            tbl[i].err, tbl[i].lat, tbl[i].rdata, tbl[i].wr, tbl[i].ewd);
    end

    // Reset during DATA of an SB: write abandoned, no response
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 12'h011; bus.req_wdata = 32'hAABBCC00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_we) cnt++;
    end
    chk("midrst stray activity", 32'(cnt), 32'd0);
    chk("midrst word kept", env_mem[4], 32'h1234DD55);
    model(1'b0, 3'd2, 12'h010, 32'd0, m_err, m_lat, m_rd, m_wr, m_wd);
    apply("after reset LW", 1'b0, 3'd2, 12'h010, 32'd0, m_err, m_lat, m_rd, m_wr, m_wd);

    // Back-to-back LW with req_valid held
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 12'h010; bus.req_wdata = 32'd0;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("b2b req_ready c%0d", c), 32'(bus.req_ready),
          (c inside {[1:3], [5:7]}) ? 32'd0 : 32'd1);
      chk($sformatf("b2b rsp_valid c%0d", c), 32'(bus.rsp_valid),
          (c == 3 || c == 7) ? 32'd1 : 32'd0);
      if (bus.rsp_valid) begin
        pulses++;
        chk("b2b rdata", bus.rsp_rdata, 32'h1234DD55);
      end
      if (c == 5) bus.req_valid = 1'b0;
    end
    chk("b2b pulse count", 32'(pulses), 32'd2);

    // Prime words 0..15, then random traffic against the model
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1'b1, 3'd2, 12'(w * 4), wd, m_err, m_lat, m_rd, m_wr, m_wd);
      apply($sformatf("prime%0d", w), 1'b1, 3'd2, 12'(w * 4), wd, m_err, m_lat, m_rd, m_wr, m_wd);
    end
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2)) | (we ? 3'd0 : {$urandom_range(0, 1) == 1, 2'b00});
      a  = 12'($urandom_range(0, 63));
      wd = $urandom;
      model(we, f3, a, wd, m_err, m_lat, m_rd, m_wr, m_wd);
      apply($sformatf("rnd%0d", i), we, f3, a, wd, m_err, m_lat, m_rd, m_wr, m_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
